// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: advance / hold / bubble / flush-to-handler with a merged
// exception code, plus saturating stall and flush counters for performance debugging.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned EXC_W      = 5,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              bubble,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  new_exc,
  input  logic              in_bd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc4,
  output logic [PC_W-1:0]   out_pc8,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [PC_W-1:0] HandlerPc = PC_W'(HANDLER_PC);
  localparam logic [PC_W-1:0] Four      = PC_W'(4);
  localparam logic [PC_W-1:0] Eight     = PC_W'(8);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic              bd_q, bd_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              hold;

  assign hold = !flush && !bubble && !en;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = HandlerPc;
      exc_d   = '0;
      bd_d    = 1'b0;
    end else if (bubble) begin
      // Bubble keeps the stalled instruction's PC/BD so its EPC stays correct.
      valid_d = 1'b0;
      data_d  = '0;
      exc_d   = '0;
      pc_d    = in_pc;
      bd_d    = in_bd;
    end else if (en) begin
      valid_d = in_valid;
      data_d  = in_data;
      pc_d    = in_pc;
      bd_d    = in_bd;
      if (!in_valid) begin
        exc_d = '0;
      end else if (in_exc != '0) begin
        exc_d = in_exc;
      end else begin
        exc_d = new_exc;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
      if (hold && valid_q && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_pc    = pc_q;
  assign out_pc4   = pc_q + Four;
  assign out_pc8   = pc_q + Eight;
  assign out_exc   = exc_q;
  assign out_bd    = bd_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed plan steps then randomized cycles, compared against an
// event-counting reference model. Two instances cover 4-bit and 16-bit counter widths.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        en, bubble, flush, clr_cnt, in_valid, in_bd;
  logic [31:0] in_data, in_pc;
  logic [4:0]  in_exc, new_exc;

  logic        out_valid, out_bd;
  logic [31:0] out_data, out_pc, out_pc4, out_pc8;
  logic [4:0]  out_exc;
  logic [3:0]  stall_cnt, flush_cnt;

  logic        w_valid, w_bd;
  logic [31:0] w_data, w_pc, w_pc4, w_pc8;
  logic [4:0]  w_exc;
  logic [15:0] w_stall, w_flush;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural outputs plus raw event counts since the last clear.
  logic        m_valid, m_bd;
  logic [31:0] m_data, m_pc;
  logic [4:0]  m_exc;
  int          stall_ev, flush_ev;

  pipe_stage_reg #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .bubble(bubble), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc), .in_exc(in_exc),
    .new_exc(new_exc), .in_bd(in_bd), .out_valid(out_valid), .out_data(out_data),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8), .out_exc(out_exc),
    .out_bd(out_bd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg dut16 (
    .clk(clk), .reset(reset), .en(en), .bubble(bubble), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc), .in_exc(in_exc),
    .new_exc(new_exc), .in_bd(in_bd), .out_valid(w_valid), .out_data(w_data),
    .out_pc(w_pc), .out_pc4(w_pc4), .out_pc8(w_pc8), .out_exc(w_exc),
    .out_bd(w_bd), .stall_cnt(w_stall), .flush_cnt(w_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int ev, input int maxv);
    return (ev > maxv) ? maxv : ev;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] p4, p8;
    p4 = m_pc + 32'd4;
    p8 = m_pc + 32'd8;
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".data"},  64'(out_data),  64'(m_data));
    chk({tag, ".pc"},    64'(out_pc),    64'(m_pc));
    chk({tag, ".pc4"},   64'(out_pc4),   64'(p4));
    chk({tag, ".pc8"},   64'(out_pc8),   64'(p8));
    chk({tag, ".exc"},   64'(out_exc),   64'(m_exc));
    chk({tag, ".bd"},    64'(out_bd),    64'(m_bd));
    chk({tag, ".stall4"},  64'(stall_cnt), 64'(sat(stall_ev, 15)));
    chk({tag, ".flush4"},  64'(flush_cnt), 64'(sat(flush_ev, 15)));
    chk({tag, ".stall16"}, 64'(w_stall),   64'(sat(stall_ev, 65535)));
    chk({tag, ".flush16"}, 64'(w_flush),   64'(sat(flush_ev, 65535)));
    chk({tag, ".pc16"},    64'(w_pc),      64'(m_pc));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_pc = '0; m_exc = '0; m_bd = 1'b0;
    stall_ev = 0; flush_ev = 0;
  endtask

  task automatic model_edge();
    bit idle_valid;
    idle_valid = !flush && !bubble && !en && m_valid;
    if (clr_cnt) begin
      stall_ev = 0;
      flush_ev = 0;
    end else begin
      if (flush) flush_ev++;
      if (idle_valid) stall_ev++;
    end
    if (flush) begin
      m_valid = 0; m_data = 0; m_pc = 32'h0000_4180; m_exc = 0; m_bd = 0;
    end else if (bubble) begin
      m_valid = 0; m_data = 0; m_exc = 0; m_pc = in_pc; m_bd = in_bd;
    end else if (en) begin
      m_valid = in_valid; m_data = in_data; m_pc = in_pc; m_bd = in_bd;
      m_exc = !in_valid ? 5'd0 : (in_exc != 0) ? in_exc : new_exc;
    end
  endtask

  // Inputs change only at negedge; one call = one rising edge plus a full check.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input bit f, input bit b, input bit e, input bit c);
    flush = f; bubble = b; en = e; clr_cnt = c;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    in_valid = 0; in_data = 0; in_pc = 0; in_exc = 0; new_exc = 0; in_bd = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Advance with exception merge
    drive(0, 0, 1, 0);
    in_valid = 1; in_data = 32'h2108_0001; in_pc = 32'h0000_3008;
    in_exc = 0; new_exc = 4; in_bd = 1;
    step("adv_new_exc");
    in_exc = 10; in_pc = 32'h0000_300C; in_bd = 0;
    step("adv_old_exc");
    in_valid = 0; in_exc = 7; new_exc = 3;
    step("adv_invalid");
    in_valid = 1; in_exc = 0; new_exc = 0; in_pc = 32'h0000_3010;
    step("adv_valid");

    // Stall counting: 5 valid holds, bubble, 3 invalid holds
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("hold_valid");
    drive(0, 1, 0, 0);
    step("bubble_mid");
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold_invalid");
    chk("stall_five", 64'(stall_cnt), 64'd5);

    // Saturation of the 4-bit counter
    drive(0, 0, 1, 0);
    in_valid = 1;
    step("reload");
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("hold_sat");
    chk("stall_sat", 64'(stall_cnt), 64'd15);

    // Reset mid-stall, between edges
    @(posedge clk);
    model_edge();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("reset_mid");
    chk("reset_pc4", 64'(out_pc4), 64'd4);
    chk("reset_pc8", 64'(out_pc8), 64'd8);
    @(negedge clk);
    reset = 1'b1;

    // Flush priority over bubble and en
    drive(1, 1, 1, 0);
    in_valid = 1; in_pc = 32'h0000_3010; in_exc = 2;
    step("flush_prio");
    chk("flush_pc8", 64'(out_pc8), 64'h4188);
    chk("flush_cnt1", 64'(flush_cnt), 64'd1);

    // Bubble beats en and keeps PC/BD
    drive(0, 1, 1, 0);
    in_pc = 32'h0000_3020; in_bd = 1;
    step("bubble_pc");

    // Back-to-back flushes, then clear together with flush
    drive(1, 0, 0, 0);
    step("flush_b2b0");
    step("flush_b2b1");
    drive(1, 0, 0, 1);
    step("flush_clr");
    chk("flush_clr_cnt", 64'(flush_cnt), 64'd0);

    // PC wrap-around
    drive(0, 0, 1, 0);
    in_pc = 32'hFFFF_FFFC;
    step("pc_wrap");

    // Randomized cycles
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      in_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      in_exc   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      new_exc  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      in_bd    = 1'($urandom);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the per-stage hand-written registers with one configurable block carrying an instruction payload, the stage PC, a merged exception code and a branch-delay flag. It supports four update modes: advance, hold, bubble insertion and exception flush to the handler PC. It also keeps saturating stall and flush counters for performance debugging.

## Interface

Parameters:
- DATA_W, 32: payload width (instruction word plus any decoded fields).
- PC_W, 32: PC width.
- EXC_W, 5: exception-code width; code 0 means no exception.
- HANDLER_PC, 32'h0000_4180: PC loaded on flush (truncated to PC_W).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  advance: capture the upstream stage.
- bubble  in  1  insert NOP (for the downstream side of a stall).
- flush  in  1  exception/eret flush request.
- clr_cnt  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream slot holds a real instruction.
- in_data  in  DATA_W  upstream payload.
- in_pc  in  PC_W  upstream PC.
- in_exc  in  EXC_W  exception already raised by an older stage.
- new_exc  in  EXC_W  exception detected at this boundary.
- in_bd  in  1  upstream instruction is in a branch-delay slot.
- out_valid  out  1  registered valid.
- out_data  out  DATA_W  registered payload.
- out_pc  out  PC_W  registered PC.
- out_pc4  out  PC_W  out_pc+4, combinational.
- out_pc8  out  PC_W  out_pc+8, combinational.
- out_exc  out  EXC_W  registered merged exception code.
- out_bd  out  1  registered branch-delay flag.
- stall_cnt  out  CNT_W  count of cycles a valid instruction was held.
- flush_cnt  out  CNT_W  count of flush events.

## Operation

The register uses a strict priority of update modes, evaluated each rising edge:

1. **reset low (asynchronous)**
   - out_valid, out_data, out_pc, out_exc and out_bd are all 0.
   - stall_cnt and flush_cnt are 0.
2. **flush**
   - out_valid=0, out_data=0, out_pc=HANDLER_PC, out_exc=0, out_bd=0.
   - flush_cnt increments.
3. **bubble**
   - out_valid=0, out_data=0, out_exc=0.
   - out_pc<=in_pc and out_bd<=in_bd, so the EPC of a bubble stays the PC of the stalled instruction.
4. **en**
   - out_valid<=in_valid, out_data<=in_data, out_pc<=in_pc, out_bd<=in_bd.
   - out_exc<=in_exc if in_exc≠0, else new_exc. The older stage always wins.
   - If in_valid=0, out_exc<=0 regardless of in_exc and new_exc.
5. **none asserted**
   - All data outputs hold.
   - stall_cnt increments if out_valid=1.

Counter rules:
- Both counters saturate at all-ones and never wrap.
- clr_cnt zeroes both counters and overrides any increment in the same cycle.
- clr_cnt does not affect the data path.

Arithmetic:
- out_pc4 and out_pc8 are computed modulo 2^PC_W, so wrap-around is silent (e.g. out_pc=32'hFFFF_FFFC gives out_pc4=0, out_pc8=4).

Flush state:
- Only out_pc is non-zero after a flush, so downstream logic sees a NOP whose PC points at the handler.

## Timing

- **Latency:** every registered output updates on the rising clk edge after its inputs are sampled, i.e. one cycle.
- **Derived PCs:** out_pc4 and out_pc8 follow out_pc in the same cycle, with no added latency.
- **Reset assertion:** takes effect immediately, without waiting for a clock edge, including in the middle of a stall or flush.
- **Reset release:** the first edge with reset high is a normal priority evaluation.
- **Simultaneous control inputs:**
  - flush+bubble+en: flush behaviour.
  - bubble+en: bubble behaviour.
  - flush+clr_cnt: data path flushes and flush_cnt ends at 0.
- **Stall counting:** a hold cycle with out_valid=0 does not count as a stall cycle.
- **Back-to-back flushes:** each flush is counted once per cycle.
- **Counter timing:** counters are registered, and a counted event is visible on the following cycle.

## Test plan

1. **Reset mid-stall**
   - Stimulus: pull reset low asynchronously between edges while out_valid=1 and en=0.
   - Required: all outputs go to 0 immediately; out_pc4=4 and out_pc8=8.
2. **Advance with exception merge**
   - Stimulus: en=1, in_valid=1, in_pc=32'h0000_3008, in_exc=0, new_exc=4, in_bd=1.
   - Required after one edge: out_pc=32'h3008, out_pc4=32'h300C, out_exc=4, out_bd=1.
   - Then repeat with in_exc=10, new_exc=4. Required: out_exc=10.
3. **Flush priority**
   - Stimulus: flush=1, bubble=1, en=1 with a valid instruction at in_pc=32'h3010.
   - Required: out_valid=0, out_pc=32'h4180, out_pc8=32'h4188, out_exc=0, flush_cnt=1.
4. **Bubble keeps PC**
   - Stimulus: bubble=1, en=1, in_pc=32'h3020, in_bd=1.
   - Required: out_valid=0, out_data=0, out_pc=32'h3020, out_bd=1.
5. **Stall counter**
   - Stimulus: hold a valid instruction for 5 cycles, then 3 hold cycles with out_valid=0.
   - Required: stall_cnt=5.
   - Then, with CNT_W=4, hold a valid instruction for 20 cycles. Required: stall_cnt=15 (saturated).
6. **Counter clear priority**
   - Stimulus: clr_cnt=1 together with flush=1.
   - Required: flush_cnt=0 next cycle and out_pc=32'h4180.
